spi_slave_core: RTL and testbench

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_defines.sv | 12 +
 rtl/spi_slave_sync.sv | 66 ++++++
 rtl/spi_slave_core.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_defines.sv
// Shared SPI definitions: default character length and slave sequencer states.
package spi_defines;

  localparam int SPI_MAX_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Pin synchronizers for the SPI slave plus mode-aware sclk edge decoding.
// All pulse outputs are registered and land 3 clk_in cycles after the pin edge.
module spi_slave_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  input  logic cpol,
  input  logic cpha,
  output logic sample_edge,
  output logic shift_edge,
  output logic ss_n_s,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic [2:0] sclk_r;
  logic [2:0] ss_r;
  logic [1:0] mosi_r;
  logic [1:0] ss_rdy;
  logic       ss_arm;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       lead_edge;
  logic       trail_edge;

  always_comb begin
    sclk_rise  = sclk_r[1] & ~sclk_r[2];
    sclk_fall  = ~sclk_r[1] & sclk_r[2];
    lead_edge  = cpol ? sclk_fall : sclk_rise;
    trail_edge = cpol ? sclk_rise : sclk_fall;
  end

  // A fall only counts once ss_n has been seen high on a real pin value, so
  // releasing reset with ss_n already low cannot start a bogus transfer.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk_r      <= '0;
      ss_r        <= '1;
      mosi_r      <= '0;
      ss_rdy      <= '0;
      ss_arm      <= 1'b0;
      sample_edge <= 1'b0;
      shift_edge  <= 1'b0;
      ss_fall     <= 1'b0;
      ss_rise     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge values.
      sclk_r      <= {sclk_r[1:0], sclk};
      ss_r        <= {ss_r[1:0], ss_n};
      mosi_r      <= {mosi_r[0], mosi};
      ss_rdy      <= {ss_rdy[0], 1'b1};
      ss_arm      <= ss_arm | (ss_rdy[1] & ss_r[1]);
      sample_edge <= cpha ? trail_edge : lead_edge;
      shift_edge  <= cpha ? lead_edge : trail_edge;
      ss_fall     <= ss_arm & ss_r[2] & ~ss_r[1];
      ss_rise     <= ~ss_r[2] & ss_r[1];
    end
  end

  assign ss_n_s = ss_r[2];
  assign mosi_s = mosi_r[1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core: holding-register transmit path, right-justified receive path
// and an IDLE/LOAD/SHIFT sequencer driven by synchronized pin edges.
module spi_slave_core
  import spi_defines::*;
#(
  parameter int MAX_LEN = SPI_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               sclk,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               lsb,
  input  logic [LEN_W-1:0]   char_len,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ack,
  output logic               rx_overrun,
  output logic               tx_underrun,
  output logic               abort
);

  localparam logic [LEN_W:0] FULL_LEN = (LEN_W+1)'(MAX_LEN);

  spi_state_e         state_q, state_d;
  logic               cpol_q, cpha_q, lsb_q;
  logic [LEN_W:0]     len_q;
  logic [MAX_LEN-1:0] hold_q;
  logic               hold_full_q;
  logic [MAX_LEN-1:0] tx_sr_q;
  logic [MAX_LEN-1:0] rx_sr_q;
  logic [LEN_W:0]     bit_cnt_q;

  logic sample_edge, shift_edge, ss_n_s, ss_fall, ss_rise, mosi_s;
  logic start, load, char_done, do_sample, do_shift, capture;
  logic [LEN_W:0] pad;

  spi_slave_sync u_sync (
    .clk_in      (clk_in),
    .rst         (rst),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .cpol        (cpol_q),
    .cpha        (cpha_q),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge),
    .ss_n_s      (ss_n_s),
    .ss_fall     (ss_fall),
    .ss_rise     (ss_rise),
    .mosi_s      (mosi_s)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (char_done) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
    if (ss_n_s) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A shift edge only advances once a bit has been sampled in this character:
  // that skips the cpha=1 leading edge and the cpha=0 edge trailing the last bit.
  always_comb begin
    start     = (state_q == ST_IDLE) && ss_fall;
    load      = (state_q == ST_LOAD);
    char_done = (state_q == ST_SHIFT) && (bit_cnt_q == len_q);
    do_sample = (state_q == ST_SHIFT) && !ss_n_s && sample_edge && (bit_cnt_q != len_q);
    do_shift  = (state_q == ST_SHIFT) && !ss_n_s && shift_edge && (bit_cnt_q != '0);
    capture   = tx_valid && !hold_full_q;
    pad       = FULL_LEN - len_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      len_q       <= FULL_LEN;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;

      if (start) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsb;
        len_q  <= (char_len == '0) ? FULL_LEN : {1'b0, char_len};
      end

      // Capture wins over the LOAD hand-off so a word written during LOAD stays held.
      if (capture) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end

      // MSB-first words are left-justified so the outgoing bit is always the top bit.
      if (load) begin
        if (hold_full_q) begin
          tx_sr_q <= lsb_q ? hold_q : (hold_q << pad);
        end else begin
          tx_sr_q     <= '1;
          tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_sr_q <= lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
      end

      if (ss_n_s || load || char_done) begin
        rx_sr_q   <= '0;
        bit_cnt_q <= '0;
      end else if (do_sample) begin
        rx_sr_q   <= lsb_q ? {mosi_s, rx_sr_q[MAX_LEN-1:1]} : {rx_sr_q[MAX_LEN-2:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (char_done) begin
        rx_data    <= lsb_q ? (rx_sr_q >> pad) : rx_sr_q;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      if (ss_rise && (bit_cnt_q != '0) && !char_done) abort <= 1'b1;
    end
  end

  assign tx_ready = !hold_full_q;
  assign miso_oe  = !ss_n_s;
  assign miso     = !ss_n_s && (lsb_q ? tx_sr_q[0] : tx_sr_q[MAX_LEN-1]);

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: the bench acts as SPI master, expected
// received words go into a scoreboard queue that a monitor drains on rx events.
module tb_spi_slave_core;

  localparam int H = 8;  // sclk half period in clk_in cycles

  logic        clk_in = 1'b0;
  logic        rst;
  logic        sclk, ss_n, mosi;
  logic        miso, miso_oe;
  logic        cpol, cpha, lsb;
  logic [4:0]  char_len;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ack;
  logic        rx_overrun, tx_underrun, abort;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cnt_ur = 0, cnt_or = 0, cnt_ab = 0;
  int          base_ur, base_or, base_ab;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic        vld_prev = 1'b0;

  spi_slave_core #(.MAX_LEN(32), .LEN_W(5)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb         (lsb),
    .char_len    (char_len),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun),
    .abort       (abort)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic snap();
    base_ur = cnt_ur;
    base_or = cnt_or;
    base_ab = cnt_ab;
  endtask

  task automatic load_tx(input string name, input logic [31:0] word);
    @(negedge clk_in);
    check({name, "_ready_before"}, 32'(tx_ready), 32'd1);
    tx_data  = word;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    check({name, "_ready_after"}, 32'(tx_ready), 32'd0);
  endtask

  task automatic ack_rx();
    @(negedge clk_in);
    rx_ack = 1'b1;
    @(negedge clk_in);
    rx_ack = 1'b0;
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    wait_cyc(8);
  endtask

  task automatic ss_high();
    wait_cyc(H);
    ss_n = 1'b1;
    wait_cyc(8);
  endtask

  // Master side of nbits of one character of length len; returns bits seen on miso.
  task automatic xfer(input int len, input int nbits, input bit lsb_first,
                      input logic [31:0] word, output logic [31:0] rd);
    int b;
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      b = lsb_first ? i : len - 1 - i;
      if (!cpha) begin
        mosi = word[b];
        wait_cyc(H);
        rd[b] = miso;
        sclk = ~sclk;
        wait_cyc(H);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = word[b];
        wait_cyc(H);
        rd[b] = miso;
        sclk = ~sclk;
        wait_cyc(H);
      end
    end
  endtask

  // Monitor: counts event pulses and checks each newly presented rx word.
  always @(negedge clk_in) begin
    if (rst) begin
      vld_prev = 1'b0;
    end else begin
      if (tx_underrun) cnt_ur++;
      if (rx_overrun)  cnt_or++;
      if (abort)       cnt_ab++;
      if ((rx_valid && !vld_prev) || rx_overrun) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_word", rx_data, 32'hxxxx_xxxx);
        end else begin
          check("rx_data_scoreboard", rx_data, exp_q.pop_front());
        end
      end
      vld_prev = rx_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; char_len = 5'd8;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
    wait_cyc(3);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_miso", 32'({miso, miso_oe}), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_pulses", 32'({rx_overrun, tx_underrun, abort}), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Mode 0, 8-bit MSB first.
    load_tx("t1", 32'hA5);
    snap();
    exp_q.push_back(32'h3C);
    ss_low();
    check("t1_miso_oe_active", 32'(miso_oe), 32'd1);
    check("t1_ready_after_load_state", 32'(tx_ready), 32'd1);
    xfer(8, 8, 1'b0, 32'h3C, got);
    check("t1_miso_word", got, 32'hA5);
    wait_cyc(12);
    check("t1_rx_valid", 32'(rx_valid), 32'd1);
    check("t1_rx_data", rx_data, 32'h3C);
    ss_high();
    check("t1_miso_oe_idle", 32'(miso_oe), 32'd0);
    check("t1_underrun_cnt", 32'(cnt_ur - base_ur), 32'd1);
    ack_rx();
    wait_cyc(2);
    check("t1_rx_valid_acked", 32'(rx_valid), 32'd0);

    // Mode 3, 32-bit LSB first.
    sclk = 1'b1;
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; char_len = 5'd0;
    wait_cyc(4);
    load_tx("t2", 32'h1234_5678);
    snap();
    exp_q.push_back(32'hDEAD_BEEF);
    ss_low();
    xfer(32, 32, 1'b1, 32'hDEAD_BEEF, got);
    check("t2_miso_word", got, 32'h1234_5678);
    ss_high();
    check("t2_rx_data", rx_data, 32'hDEAD_BEEF);
    check("t2_underrun_cnt", 32'(cnt_ur - base_ur), 32'd1);
    ack_rx();
    sclk = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; char_len = 5'd8;
    wait_cyc(8);

    // Back-to-back characters, holding register empty for the second.
    load_tx("t3", 32'h5A);
    snap();
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    ss_low();
    xfer(8, 8, 1'b0, 32'h11, got);
    check("t3_miso_first", got, 32'h5A);
    ack_rx();
    check("t3_underrun_first", 32'(cnt_ur - base_ur), 32'd1);
    xfer(8, 8, 1'b0, 32'h22, got);
    check("t3_miso_second", got, 32'hFF);
    ss_high();
    check("t3_underrun_total", 32'(cnt_ur - base_ur), 32'd2);
    check("t3_no_overrun", 32'(cnt_or - base_or), 32'd0);
    ack_rx();

    // Two characters without acknowledge in between.
    load_tx("t4", 32'h33);
    snap();
    exp_q.push_back(32'h96);
    exp_q.push_back(32'h69);
    ss_low();
    xfer(8, 8, 1'b0, 32'h96, got);
    xfer(8, 8, 1'b0, 32'h69, got);
    wait_cyc(4);
    check("t4_overrun_cnt", 32'(cnt_or - base_or), 32'd1);
    check("t4_rx_data", rx_data, 32'h69);
    check("t4_rx_valid", 32'(rx_valid), 32'd1);
    ss_high();
    ack_rx();

    // Abort after 5 of 8 bits, stray sclk with ss_n high, then a clean character.
    load_tx("t5", 32'hC3);
    snap();
    ss_low();
    xfer(8, 5, 1'b0, 32'hE7, got);
    ss_high();
    check("t5_abort_cnt", 32'(cnt_ab - base_ab), 32'd1);
    check("t5_no_rx_valid", 32'(rx_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      wait_cyc(H);
    end
    mosi = 1'b0;
    check("t5_idle_sclk_ignored", 32'({rx_valid, 1'(cnt_ab - base_ab)}), 32'b01);
    load_tx("t5b", 32'h0F);
    exp_q.push_back(32'h81);
    ss_low();
    xfer(8, 8, 1'b0, 32'h81, got);
    check("t5_miso_fresh_word", got, 32'h0F);
    ss_high();
    check("t5_abort_total", 32'(cnt_ab - base_ab), 32'd1);
    check("t5_underrun_cnt", 32'(cnt_ur - base_ur), 32'd1);
    ack_rx();

    // Reset in the middle of a character.
    load_tx("t6", 32'h77);
    ss_low();
    xfer(8, 3, 1'b0, 32'hFF, got);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    snap();
    wait_cyc(10);
    check("t6_tx_ready", 32'(tx_ready), 32'd1);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    ss_high();
    check("t6_no_events", 32'((cnt_ur - base_ur) + (cnt_or - base_or) + (cnt_ab - base_ab)), 32'd0);

    // Mode 1 with char_len changed mid-transfer (must be ignored).
    cpha = 1'b1;
    load_tx("t7", 32'h3A);
    snap();
    exp_q.push_back(32'hC5);
    ss_low();
    char_len = 5'd4;
    xfer(8, 8, 1'b0, 32'hC5, got);
    check("t7_miso_word", got, 32'h3A);
    ss_high();
    check("t7_rx_data", rx_data, 32'hC5);
    ack_rx();
    char_len = 5'd8;
    cpha = 1'b0;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_in);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
